data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised byte-addressed data memory for the single-cycle/multicycle CPU data path.
- Successor to the plain combinational-read data memory.
- Adds byte/half/word access sizes, sign/zero extension on loads, misalignment detection, configurable wait states and a request/ready/valid handshake.
- Sits between the ALU address output and the writeback mux; the CPU stalls on req_ready low.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32.
- ADDR_WIDTH, 32, address port width.
- RAM_DEPTH, 256, storage size in bytes; must be a power of 2.
- WAIT_STATES, 1, extra cycles between accept and response. Range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs_ram  input  1  chip select; a request exists when cs_ram & (we | oe).
- we  input  1  write request.
- oe  input  1  read request.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- unsigned_ld  input  1  1 selects zero extension on byte/half loads; 0 selects sign extension.
- d_addr  input  ADDR_WIDTH  byte address; used modulo RAM_DEPTH.
- d_in  input  DATA_WIDTH  store data; low bytes are used per size.
- req_ready  output  1  high when in IDLE; a request is accepted on any edge where it is present and req_ready=1.
- d_out  output  DATA_WIDTH  load data, extended per size; valid only with d_valid.
- d_valid  output  1  one-cycle completion pulse for both reads and writes.
- misalign  output  1  asserted with d_valid when the accepted access was misaligned.
- busy  output  1  equals ~req_ready.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=1, busy=0, d_valid=0, misalign=0, d_out=0, wait counter=0.
  - Memory contents are not reset.
  - Reset during WAIT/RESP aborts the access; a pending write is dropped and no d_valid is produced.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on accept, latch addr, size, unsigned_ld, d_in and op. Go to WAIT if WAIT_STATES>0, else RESP. Counter is loaded with WAIT_STATES-1.
  - WAIT: counter decrements each cycle; at 0 go to RESP.
  - RESP: for one cycle, d_valid=1, then return to IDLE. req_ready goes high the cycle after RESP, so back-to-back throughput is one access per WAIT_STATES+2 cycles.
  - Latency: accept edge to d_valid high is WAIT_STATES+1 cycles.
- Operation select: if both we and oe are set, the access is a write; d_out=0 for that response.
- Alignment:
  - A half with addr[0]=1 is misaligned.
  - A word with addr[1:0]!=0 is misaligned.
  - Byte accesses are never misaligned.
  - A misaligned access performs no memory read or write; the response is d_valid=1, misalign=1, d_out=0.
- Write: performed on the clock edge leaving RESP.
  - Little-endian: d_in[7:0] goes to ram[a], d_in[15:8] to ram[a+1], and so on, for 1/2/4 bytes per size.
  - Other bytes are untouched.
  - Byte index a+k wraps modulo RAM_DEPTH.
- Read: d_out is registered and driven during the RESP cycle.
  - Byte: ram[a], extended to 32 bits.
  - Half: {ram[a+1], ram[a]}, extended.
  - Word: {ram[a+3], ram[a+2], ram[a+1], ram[a]}.
  - Outside RESP, d_out=0 and misalign=0.
- Input changes while busy are ignored because they are latched at accept.
- A request with cs_ram=0 is never accepted, regardless of we/oe.

Test Plan:
- Reset then word store: addr 0x10, d_in 0xDEADBEEF, WAIT_STATES=1. Required: d_valid pulses exactly 2 cycles after accept. A following word load from 0x10 returns 0xDEADBEEF; byte load from 0x13 returns 0xFFFFFFDE signed and 0x000000DE with unsigned_ld=1.
- Half store 0x8001 to 0x22 over word 0x11223344 at 0x20. Required: word load from 0x20 returns 0x80013344; signed half load from 0x22 returns 0xFFFF8001.
- Misaligned word store to 0x21 and misaligned half load from 0x23. Required: misalign=1 with d_valid, d_out=0, and memory at 0x20 unchanged.
- Wrap-around: word store 0xA1B2C3D4 to 0xFE. Required: misalign=1. Byte stores to 0xFF and to 0x100 (aliasing to 0x00) land in bytes 0xFF and 0x00.
- Back-to-back requests held high with WAIT_STATES=0. Required: req_ready toggles 1,0,1,0; one d_valid per 2 cycles; the we&oe request is treated as a write.
- Assert rst_n low while in WAIT for a store to 0x40. Required: no d_valid, req_ready=1 immediately, and location 0x40 keeps its old value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressed data memory with byte/half/word accesses,
//               sign/zero-extended loads, misalignment detection, configurable
//               wait states and a request/ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_ram,
    input  logic                  we,
    input  logic                  oe,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_valid,
    output logic                  misalign,
    output logic                  busy
);

    localparam int IDX = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [3:0]              cnt, cnt_nx;
    logic [IDX-1:0]          lat_addr;
    logic [1:0]              lat_size;
    logic                    lat_uns;
    logic                    lat_we;
    logic                    lat_mis;
    logic [DATA_WIDTH-1:0]   lat_din;
    logic [7:0]              ram [RAM_DEPTH];

    logic                    req;
    logic                    accept;
    logic                    req_mis;
    logic [IDX-1:0]          src_addr;
    logic [1:0]              src_size;
    logic                    src_uns;
    logic                    src_we;
    logic                    src_mis;
    logic [7:0]              b0, b1, b2, b3;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    unused_addr_bits;

    // Address bits above the RAM index only alias, they are never decoded.
    assign unused_addr_bits = &{1'b0, d_addr[ADDR_WIDTH-1:IDX]};

    assign req       = cs_ram & (we | oe);
    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign d_valid   = (state == RESP);
    assign accept    = req & req_ready;

    // Misalignment of the incoming request; bytes are always aligned.
    always_comb begin
        req_mis = 1'b0;
        case (size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = d_addr[0];
            default: req_mis = |d_addr[1:0];
        endcase
    end

    // With zero wait states RESP is entered on the accept edge itself, so the
    // read data must come from the live inputs rather than the latched copy.
    always_comb begin
        src_addr = lat_addr;
        src_size = lat_size;
        src_uns  = lat_uns;
        src_we   = lat_we;
        src_mis  = lat_mis;
        if (state == IDLE) begin
            src_addr = d_addr[IDX-1:0];
            src_size = size;
            src_uns  = unsigned_ld;
            src_we   = we;
            src_mis  = req_mis;
        end
    end

    // Little-endian gather and extension of load data; index wraps in RAM.
    always_comb begin
        b0 = ram[src_addr];
        b1 = ram[src_addr + IDX'(1)];
        b2 = ram[src_addr + IDX'(2)];
        b3 = ram[src_addr + IDX'(3)];
        rd_data = '0;
        case (src_size)
            2'b00:   rd_data = src_uns ? {{(DATA_WIDTH-8){1'b0}}, b0}
                                       : {{(DATA_WIDTH-8){b0[7]}}, b0};
            2'b01:   rd_data = src_uns ? {{(DATA_WIDTH-16){1'b0}}, b1, b0}
                                       : {{(DATA_WIDTH-16){b1[7]}}, b1, b0};
            default: rd_data = {b3, b2, b1, b0};
        endcase
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nx = RESP;
                        cnt_nx   = 4'd0;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_size <= 2'b00;
            lat_uns  <= 1'b0;
            lat_we   <= 1'b0;
            lat_mis  <= 1'b0;
            lat_din  <= '0;
            d_out    <= '0;
            misalign <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_addr <= d_addr[IDX-1:0];
                lat_size <= size;
                lat_uns  <= unsigned_ld;
                lat_we   <= we;
                lat_mis  <= req_mis;
                lat_din  <= d_in;
            end
            if (state_nx == RESP) begin
                d_out    <= (src_we | src_mis) ? '0 : rd_data;
                misalign <= src_mis;
            end else begin
                d_out    <= '0;
                misalign <= 1'b0;
            end
        end
    end

    // Store commits on the edge leaving RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_we && !lat_mis) begin
            ram[lat_addr] <= lat_din[7:0];
            if (lat_size != 2'b00) begin
                ram[lat_addr + IDX'(1)] <= lat_din[15:8];
            end
            if (lat_size[1]) begin
                ram[lat_addr + IDX'(2)] <= lat_din[23:16];
                ram[lat_addr + IDX'(3)] <= lat_din[31:24];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl, one instance
//               with one wait state and one with zero wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cs1, cs0;
    logic        we, oe, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] d_addr, d_in;
    logic        req_ready1, d_valid1, misalign1, busy1;
    logic        req_ready0, d_valid0, misalign0, busy0;
    logic [31:0] d_out1, d_out0;

    int total = 0;
    int bad   = 0;

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .cs_ram(cs1), .we(we), .oe(oe), .size(size),
        .unsigned_ld(unsigned_ld), .d_addr(d_addr), .d_in(d_in),
        .req_ready(req_ready1), .d_out(d_out1), .d_valid(d_valid1),
        .misalign(misalign1), .busy(busy1)
    );

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .cs_ram(cs0), .we(we), .oe(oe), .size(size),
        .unsigned_ld(unsigned_ld), .d_addr(d_addr), .d_in(d_in),
        .req_ready(req_ready0), .d_out(d_out0), .d_valid(d_valid0),
        .misalign(misalign0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request to the selected instance (sel=1 -> zero-wait DUT),
    // wait a bounded number of cycles for d_valid and return what was seen.
    task automatic access(input bit sel, input logic w, input logic o,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] din,
                          output logic [31:0] dout, output logic mis,
                          output int lat);
        @(negedge clk);
        we = w; oe = o; size = sz; unsigned_ld = u; d_addr = a; d_in = din;
        if (sel) cs0 = 1'b1; else cs1 = 1'b1;
        @(posedge clk);
        #1;
        cs0 = 1'b0; cs1 = 1'b0; we = 1'b0; oe = 1'b0;
        dout = '0; mis = 1'b0; lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (sel ? d_valid0 : d_valid1) begin
                dout = sel ? d_out0 : d_out1;
                mis  = sel ? misalign0 : misalign1;
                lat  = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", req_ready1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
        total++; if (d_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", d_valid1); end
        total++; if (misalign1 !== 1'b0) begin bad++; $display("FAIL reset_mis1 got=%b want=0", misalign1); end
        total++; if (d_out1 !== 32'h0) begin bad++; $display("FAIL reset_dout1 got=%h want=0", d_out1); end
        total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b want=1", req_ready0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        logic [31:0] r; logic m; int l;
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r, m, l);
        total++; if (l !== 2) begin bad++; $display("FAIL store_latency got=%0d want=2", l); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL store_dout got=%h want=0", r); end
        access(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, r, m, l);
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load got=%h want=deadbeef", r); end
        total++; if (m !== 1'b0) begin bad++; $display("FAIL word_load_mis got=%b want=0", m); end
        total++; if (d_out1 !== 32'h0) begin bad++; $display("FAIL dout_idle got=%h want=0", d_out1); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0, r, m, l);
        total++; if (r !== 32'hFFFFFFDE) begin bad++; $display("FAIL byte_signed got=%h want=ffffffde", r); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, r, m, l);
        total++; if (r !== 32'h000000DE) begin bad++; $display("FAIL byte_unsigned got=%h want=000000de", r); end
    endtask

    task automatic test_half();
        logic [31:0] r; logic m; int l;
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h11223344, r, m, l);
        access(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, r, m, l);
        access(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, r, m, l);
        total++; if (r !== 32'h80013344) begin bad++; $display("FAIL half_merge got=%h want=80013344", r); end
        access(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0, r, m, l);
        total++; if (r !== 32'hFFFF8001) begin bad++; $display("FAIL half_signed got=%h want=ffff8001", r); end
        access(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h0, r, m, l);
        total++; if (r !== 32'h00008001) begin bad++; $display("FAIL half_unsigned got=%h want=00008001", r); end
    endtask

    task automatic test_misalign();
        logic [31:0] r; logic m; int l;
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'hCAFEBABE, r, m, l);
        total++; if (m !== 1'b1) begin bad++; $display("FAIL mis_word_store got=%b want=1", m); end
        total++; if (misalign1 !== 1'b0) begin bad++; $display("FAIL mis_idle got=%b want=0", misalign1); end
        access(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0, r, m, l);
        total++; if (m !== 1'b1) begin bad++; $display("FAIL mis_half_load got=%b want=1", m); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL mis_half_dout got=%h want=0", r); end
        access(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, r, m, l);
        total++; if (r !== 32'h80013344) begin bad++; $display("FAIL mis_mem_kept got=%h want=80013344", r); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h21, 32'h0, r, m, l);
        total++; if (m !== 1'b0 || r !== 32'h33) begin bad++; $display("FAIL byte_odd got=%h/%b want=00000033/0", r, m); end
    endtask

    task automatic test_wrap();
        logic [31:0] r; logic m; int l;
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hFE, 32'hA1B2C3D4, r, m, l);
        total++; if (m !== 1'b1) begin bad++; $display("FAIL wrap_word_mis got=%b want=1", m); end
        access(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFF, 32'h0000005A, r, m, l);
        access(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h000000A5, r, m, l);
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'hFF, 32'h0, r, m, l);
        total++; if (r !== 32'h5A) begin bad++; $display("FAIL wrap_byte_ff got=%h want=0000005a", r); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, r, m, l);
        total++; if (r !== 32'hA5) begin bad++; $display("FAIL wrap_byte_00 got=%h want=000000a5", r); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h200, 32'h0, r, m, l);
        total++; if (r !== 32'hFFFFFFA5) begin bad++; $display("FAIL wrap_alias_200 got=%h want=ffffffa5", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic m; int l;
        logic [3:0] exp_ready;
        logic [3:0] exp_valid;
        exp_ready = 4'b0101; // index 0 first: 1,0,1,0
        exp_valid = 4'b1010; // index 0 first: 0,1,0,1
        @(negedge clk);
        we = 1'b1; oe = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
        d_addr = 32'h30; d_in = 32'h12345678; cs0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (req_ready0 !== exp_ready[i]) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, req_ready0, exp_ready[i]); end
            total++; if (d_valid0 !== exp_valid[i]) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=%b", i, d_valid0, exp_valid[i]); end
            total++; if (d_out0 !== 32'h0) begin bad++; $display("FAIL b2b_dout[%0d] got=%h want=0", i, d_out0); end
            if (i < 3) @(negedge clk);
        end
        cs0 = 1'b0; we = 1'b0; oe = 1'b0;
        @(negedge clk);
        access(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, r, m, l);
        total++; if (l !== 1) begin bad++; $display("FAIL ws0_latency got=%0d want=1", l); end
        total++; if (r !== 32'h12345678) begin bad++; $display("FAIL b2b_write got=%h want=12345678", r); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic m; int l;
        logic seen;
        access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, r, m, l);
        @(negedge clk);
        we = 1'b1; oe = 1'b0; size = 2'b10; d_addr = 32'h40; d_in = 32'h77777777; cs1 = 1'b1;
        @(posedge clk);
        #1;
        cs1 = 1'b0; we = 1'b0;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL abort_in_wait got=%b want=1", busy1); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", req_ready1); end
        seen = d_valid1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (d_valid1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0", seen); end
        access(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, r, m, l);
        total++; if (r !== 32'h0BADF00D) begin bad++; $display("FAIL abort_mem_kept got=%h want=0badf00d", r); end
    endtask

    initial begin
        rst_n = 1'b0; cs1 = 1'b0; cs0 = 1'b0; we = 1'b0; oe = 1'b0;
        size = 2'b00; unsigned_ld = 1'b0; d_addr = '0; d_in = '0;
        test_reset();
        test_word_store();
        test_half();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
